// File: rtl/acia_pkg.sv
// Shared ACIA definitions: FSM state encodings and default baud/FIFO sizing,
// common to the receiver and the future transmitter.
package acia_pkg;

  localparam int ACIA_BAUD_DIV_DEF   = 87;  // 10 MHz clk / 115200 baud
  localparam int ACIA_FIFO_DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } acia_state_e;

endpackage

// File: rtl/acia_rx_if.sv
// Receiver bus: serial line in, FIFO pop/flags out, plus the FSM state for observation.
// Handshake: rx_valid means rx_data holds the oldest byte; a one-clk rd while
// rx_valid is high consumes it, and rd while rx_valid is low has no effect.
interface acia_rx_if
  import acia_pkg::*;
#(
  parameter int FIFO_DEPTH = ACIA_FIFO_DEPTH_DEF
) ();

  logic                          rx_in;
  logic                          rd;
  logic                          clr_err;
  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic [$clog2(FIFO_DEPTH):0]   rx_count;
  logic                          overrun;
  logic                          frame_err;
  acia_state_e                   state;

  modport master (
    output rx_in, rd, clr_err,
    input  rx_data, rx_valid, rx_count, overrun, frame_err, state
  );

  modport slave (
    input  rx_in, rd, clr_err,
    output rx_data, rx_valid, rx_count, overrun, frame_err, state
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO: data_o always shows the oldest entry.
// A push while full is accepted only when a pop happens in the same clk.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/acia_rx.sv
// 8N1 asynchronous receiver: synchronizer, mid-bit sampling FSM with break
// handling, receive FIFO and sticky overrun/framing flags.
module acia_rx
  import acia_pkg::*;
#(
  parameter int BAUD_DIV   = ACIA_BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = ACIA_FIFO_DEPTH_DEF
) (
  input logic       clk,
  input logic       reset,
  acia_rx_if.slave  bus
);

  localparam int              CNT_W     = 12;
  localparam logic [CNT_W-1:0] BIT_TIME  = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_TIME = CNT_W'(BAUD_DIV / 2);

  logic [2:0]       sync_q;
  logic             rx_s, fall;
  acia_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             push, frame_set, expired;
  logic             overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic             fifo_empty, fifo_full;

  // sync_q[1] is the synchronized line; sync_q[2] is its previous value.
  assign rx_s    = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];
  assign expired = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 3'b111;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[1:0], bus.rx_in};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (fall) begin
          state_d = ST_START;
          cnt_d   = HALF_TIME;
        end
      end
      ST_START: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_s) begin
          state_d = ST_DATA;
          cnt_d   = BIT_TIME;
        end else begin
          state_d = ST_IDLE;  // start bit vanished: treat as a glitch
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          cnt_d   = BIT_TIME;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!expired) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A set event takes priority over a coincident clear.
  always_comb begin
    overrun_d   = (push && fifo_full && !bus.rd) || (overrun_q && !bus.clr_err);
    frame_err_d = frame_set || (frame_err_q && !bus.clr_err);
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (bus.rd),
    .data_o  (bus.rx_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (bus.rx_count)
  );

  assign bus.rx_valid  = ~fifo_empty;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_acia_rx.sv
// Directed bench for acia_rx at BAUD_DIV=16, FIFO_DEPTH=4: normal frames,
// glitch rejection, framing/break, overrun, mid-frame reset and flag priority.
module tb_acia_rx;
  import acia_pkg::*;

  localparam int BAUD  = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  acia_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  acia_rx #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame, 16 clks per bit; the stop-bit mid-sample lands on the clk
  // following iteration 154, where optional rd / clr_err pulses are placed.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input bit rd_at_stop, input bit clr_at_stop);
    for (int i = 0; i < 10 * BAUD; i++) begin
      @(negedge clk);
      if (i < BAUD)           bus.rx_in = 1'b0;
      else if (i < 9 * BAUD)  bus.rx_in = data[(i - BAUD) / BAUD];
      else                    bus.rx_in = stop;
      bus.rd = rd_at_stop && (i == 154);
      if (clr_at_stop && i == 155) check("frame_err_set_beats_clr", 32'(bus.frame_err), 32'd1);
      bus.clr_err = clr_at_stop && (i == 154 || i == 155);
    end
    @(negedge clk);
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, 32'(bus.rx_data), 32'(exp));
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.rx_in   = 1'b1;
    bus.rd      = 1'b0;
    bus.clr_err = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);
    check("reset_valid",     32'(bus.rx_valid),  32'd0);
    check("reset_count",     32'(bus.rx_count),  32'd0);
    check("reset_overrun",   32'(bus.overrun),   32'd0);
    check("reset_frame_err", 32'(bus.frame_err), 32'd0);
    check("reset_state",     32'(bus.state),     32'(ST_IDLE));

    // Two good frames
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("two_count", 32'(bus.rx_count), 32'd2);
    check("two_valid", 32'(bus.rx_valid), 32'd1);
    pop_check("two_head_55", 8'h55);
    pop_check("two_next_a3", 8'hA3);
    check("two_empty",     32'(bus.rx_valid),  32'd0);
    check("two_overrun",   32'(bus.overrun),   32'd0);
    check("two_frame_err", 32'(bus.frame_err), 32'd0);

    // Quarter-bit glitch
    bus.rx_in = 1'b0;
    idle(BAUD / 4);
    bus.rx_in = 1'b1;
    check("glitch_start", 32'(bus.state), 32'(ST_START));
    idle(20);
    check("glitch_idle",      32'(bus.state),     32'(ST_IDLE));
    check("glitch_count",     32'(bus.rx_count),  32'd0);
    check("glitch_frame_err", 32'(bus.frame_err), 32'd0);
    check("glitch_overrun",   32'(bus.overrun),   32'd0);

    // Framing error followed by 40 bit-times of held-low line
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(20 * BAUD);
    check("brk_state",     32'(bus.state),     32'(ST_BREAK));
    check("brk_frame_err", 32'(bus.frame_err), 32'd1);
    check("brk_count",     32'(bus.rx_count),  32'd0);
    pulse_clr();
    idle(20 * BAUD);
    check("brk_single_event", 32'(bus.frame_err), 32'd0);
    check("brk_still_break",  32'(bus.state),     32'(ST_BREAK));
    bus.rx_in = 1'b1;
    idle(4);
    check("brk_exit_idle", 32'(bus.state), 32'(ST_IDLE));
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("after_brk_count", 32'(bus.rx_count), 32'd1);
    pop_check("after_brk_81", 8'h81);

    // Overrun: five bytes into a four-entry FIFO
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0);
    idle(4);
    check("ovr_count",   32'(bus.rx_count), 32'd4);
    check("ovr_flag",    32'(bus.overrun),  32'd1);
    check("ovr_fe",      32'(bus.frame_err), 32'd0);
    pop_check("ovr_pop_01", 8'h01);
    pop_check("ovr_pop_02", 8'h02);
    pop_check("ovr_pop_03", 8'h03);
    pop_check("ovr_pop_04", 8'h04);
    check("ovr_drained", 32'(bus.rx_valid), 32'd0);
    check("ovr_sticky",  32'(bus.overrun),  32'd1);
    pulse_clr();
    check("ovr_cleared", 32'(bus.overrun),  32'd0);

    // Fifth push coinciding with rd while full
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, 1'b1, 1'b0);
    idle(4);
    check("pushrd_count",   32'(bus.rx_count), 32'd4);
    check("pushrd_overrun", 32'(bus.overrun),  32'd0);
    pop_check("pushrd_pop_02", 8'h02);
    pop_check("pushrd_pop_03", 8'h03);
    pop_check("pushrd_pop_04", 8'h04);
    pop_check("pushrd_pop_05", 8'h05);
    check("pushrd_drained", 32'(bus.rx_valid), 32'd0);

    // Reset during data bit 4 of 0xFF
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      bus.rx_in = (i < BAUD) ? 1'b0 : 1'b1;
    end
    check("rst_mid_in_data", 32'(bus.state), 32'(ST_DATA));
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    check("rst_mid_valid",  32'(bus.rx_valid),  32'd0);
    check("rst_mid_count",  32'(bus.rx_count),  32'd0);
    check("rst_mid_flags",  32'({bus.overrun, bus.frame_err}), 32'd0);
    check("rst_mid_state",  32'(bus.state),     32'(ST_IDLE));
    idle(8 * BAUD);
    check("rst_mid_no_push", 32'(bus.rx_valid), 32'd0);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("rst_next_count", 32'(bus.rx_count), 32'd1);
    pop_check("rst_next_12", 8'h12);

    // clr_err coinciding with the frame-error set, then alone
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    check("clr_after_fe",    32'(bus.frame_err), 32'd0);
    check("clr_after_state", 32'(bus.state),     32'(ST_BREAK));
    bus.rx_in = 1'b1;
    idle(4);
    check("clr_final_idle",  32'(bus.state),     32'(ST_IDLE));
    check("clr_final_count", 32'(bus.rx_count),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/acia_rx.md
ACIA_RX -- requirements
Module: acia_rx

Interface
REQ-001 Parameter BAUD_DIV, default 87, clk cycles per bit (10 MHz clk, 115200 baud); legal range 8..4095.
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-003 clk  input  1  system clock; the block uses one clock, and all logic is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_in  input  1  raw serial line from the pad buffer, asynchronous, idle high.
REQ-006 rd  input  1  pop strobe, one clk per byte.
REQ-007 clr_err  input  1  clears sticky error flags.
REQ-008 rx_data  output  8  FIFO head byte (first-word fall-through).
REQ-009 rx_valid  output  1  FIFO non-empty.
REQ-010 rx_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-011 overrun  output  1  sticky: byte lost because the FIFO was full.
REQ-012 frame_err  output  1  sticky: stop bit sampled low.

Function
REQ-013 rx_in SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-015 IDLE: on a synchronized 1->0 transition, go to START and load the bit counter with BAUD_DIV/2 (integer divide).
REQ-016 START: at counter expiry, sample the line; if 0, go to DATA with the counter at BAUD_DIV; if 1 (glitch), return to IDLE with no flag change.
REQ-017 DATA: sample once every BAUD_DIV clks, 8 bits, LSB first, shifting into the shift register; after bit 7, go to STOP.
REQ-018 STOP: sample after BAUD_DIV clks; if 1, push the byte and go to IDLE; if 0, set frame_err, discard the byte and go to BREAK.
REQ-019 BREAK: stay until the synchronized line is 1, then go to IDLE; this prevents a held-low line from producing repeated frames.
REQ-020 Push SHALL occur in the same clk as the stop-bit sample; rx_valid SHALL rise the following clk.
REQ-021 The FIFO SHALL be first-word fall-through: rx_data always equals the oldest entry; it holds a don't-care value when empty.
REQ-022 rd while empty SHALL be ignored, with no pointer or count change.
REQ-023 Push while full, without a simultaneous rd, SHALL drop the new byte and set overrun; the FIFO contents are unchanged.
REQ-024 Simultaneous push and rd while full SHALL accept both; count is unchanged and overrun is not set.
REQ-025 Simultaneous push and rd while non-full and non-empty SHALL leave count unchanged.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; rx_count SHALL range 0..FIFO_DEPTH inclusive.
REQ-027 clr_err SHALL clear both sticky flags next clk; if a set event coincides with clr_err, the set wins.
REQ-028 Latency from the stop-bit mid-sample to rx_valid SHALL be 1 clk, plus 2 clks of synchronizer delay relative to the raw pin.

Reset
REQ-029 Reset SHALL force: FSM to IDLE; counters to 0; synchronizer flops to 1; FIFO empty (rx_valid=0, rx_count=0); overrun=0; frame_err=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame, push nothing and set no flags; reception resumes at the next falling edge after reset releases.
REQ-031 rx_data SHALL have no reset requirement, since the FIFO RAM may map to EBR.

Structure
REQ-032 FSM state encodings and the default BAUD_DIV/FIFO_DEPTH constants SHALL live in shared package acia_pkg, reused by the future acia_tx.
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo (parameters: width, depth; FWFT), instantiated once.
REQ-034 The total implementation SHALL stay within 120-400 lines of RTL, with no vendor primitives.

Verification
REQ-035 Run with BAUD_DIV=16, FIFO_DEPTH=4. Send 0x55 then 0xA3 with stop=1 -> rx_count=2; rx_data=0x55; after rd, rx_data=0xA3; no flags set.
REQ-036 Send a 0.25-bit low glitch -> no push; FSM back in IDLE; flags 0.
REQ-037 Send 0x3C with stop=0, then hold the line low for 40 bit-times -> frame_err=1, exactly one event, no push; a subsequent 0x81 is received correctly.
REQ-038 Send 5 bytes 0x01..0x05 with no rd -> rx_count=4, overrun=1, head=0x01; pop order is 0x01..0x04. Repeat with rd pulsed in the same clk as the 5th push -> overrun=0, count=4.
REQ-039 Assert reset at DATA bit 4 of 0xFF -> after release, rx_valid=0 and flags 0; the next frame 0x12 is received correctly.
REQ-040 Pulse clr_err in the same clk as a frame-error set -> frame_err=1; pulse clr_err alone on the next clk -> frame_err=0.
